toeplitz_ctrl: RTL and testbench

- Sequencing controller in front of the parallel Toeplitz extractor (toeplitz_p).
- The extractor consumes WIDTH raw bits every clock, with no enable, and emits an L-bit result with a one-cycle qstrobe per N-bit block. A stalled input mid-block would corrupt the hash.
- This block buffers one full N-bit block from a bursty valid/ready source, phase-aligns the extractor with a one-cycle reset, and streams the block gap-free.
- It captures the extractor result into a valid/ready output register that feeds the serializer or the host.

---
 rtl/toeplitz_ctrl.sv | 139 +++++++++++++
 tb/tb_toeplitz_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toeplitz_ctrl.sv
// toeplitz_ctrl: buffers one N-bit raw block, phase-aligns toeplitz_p with a
// one-cycle reset, streams the block gap-free, then captures the result.
//
// Handshakes: a beat moves on in_* when in_valid && in_ready in the same cycle;
// a result moves on out_* when out_valid && out_ready. in_ready never depends on
// in_valid, out_valid never depends on out_ready, and out_q is stable while
// out_valid is high.
module toeplitz_ctrl #(
  parameter int N       = 256,
  parameter int L       = 128,
  parameter int WIDTH   = 2,
  parameter int LAT_MAX = 8,
  parameter int CNTW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ext_reset,
  output logic [WIDTH-1:0] ext_data,
  input  logic [L-1:0]     ext_q,
  input  logic             ext_qstrobe,
  output logic [L-1:0]     out_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNTW-1:0]  blk_count,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int NBEATS = N / WIDTH;
  localparam int CW     = $clog2(NBEATS + LAT_MAX + 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_ARM    = 2'd1,
    S_STREAM = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  blk_buf;
  // Beat count in FILL/STREAM, elapsed-cycle count in WAIT.
  logic [CW-1:0] cnt;

  logic in_fire;
  logic full_now;
  logic slot_free;
  logic last_beat;
  logic timeout;

  assign in_fire   = in_valid && in_ready;
  // The block counts as full on the cycle its last beat is accepted, so ARM
  // follows the final fill cycle directly.
  assign full_now  = (cnt == CW'(NBEATS)) || ((cnt == CW'(NBEATS - 1)) && in_fire);
  assign slot_free = !out_valid || out_ready;
  assign last_beat = (cnt == CW'(NBEATS - 1));
  assign timeout   = (cnt == CW'(LAT_MAX - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FILL;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:   if (full_now && slot_free) state_nxt = S_ARM;
      S_ARM:    state_nxt = S_STREAM;
      S_STREAM: if (last_beat) state_nxt = S_WAIT;
      S_WAIT:   if (ext_qstrobe || timeout) state_nxt = S_FILL;
      default:  state_nxt = S_FILL;
    endcase
  end

  // Outputs decoded from state; reset forces the extractor reset and idle data.
  always_comb begin
    in_ready  = !reset && (state == S_FILL) && (cnt < CW'(NBEATS));
    ext_reset = reset || (state == S_ARM);
    ext_data  = '0;
    if (!reset && (state == S_STREAM)) ext_data = blk_buf[N-1 -: WIDTH];
    busy      = (state != S_FILL);
    dbg_state = state;
  end

  // Block buffer, counter, result register, block counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_buf   <= '0;
      cnt       <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      blk_count <= '0;
      err       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (ext_qstrobe && (state != S_WAIT)) err <= 1'b1;
      case (state)
        S_FILL: begin
          if (in_fire) begin
            blk_buf <= {blk_buf[N-WIDTH-1:0], in_data};
            cnt     <= cnt + CW'(1);
          end
          if (full_now && slot_free) cnt <= '0;
        end
        S_ARM: begin
          cnt <= '0;
        end
        S_STREAM: begin
          blk_buf <= {blk_buf[N-WIDTH-1:0], {WIDTH{1'b0}}};
          if (last_beat) cnt <= '0;
          else           cnt <= cnt + CW'(1);
        end
        S_WAIT: begin
          if (ext_qstrobe) begin
            out_q     <= ext_q;
            out_valid <= 1'b1;
            blk_count <= blk_count + CNTW'(1);
            blk_buf   <= '0;
            cnt       <= '0;
          end else if (timeout) begin
            err     <= 1'b1;
            blk_buf <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_toeplitz_ctrl.sv
// tb_toeplitz_ctrl: drives bursty raw blocks into toeplitz_ctrl, emulates
// toeplitz_p (strobe one cycle after the last beat, q = XOR fold of the block)
// and checks every cycle against a block-level model of expected results.
module tb_toeplitz_ctrl;

  localparam int N       = 256;
  localparam int L       = 128;
  localparam int WIDTH   = 2;
  localparam int LAT_MAX = 8;
  localparam int CNTW    = 16;
  localparam int NBEATS  = N / WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ext_reset;
  logic [WIDTH-1:0] ext_data;
  logic [L-1:0]     ext_q;
  logic             ext_qstrobe;
  logic [L-1:0]     out_q;
  logic             out_valid;
  logic             out_ready;
  logic [CNTW-1:0]  blk_count;
  logic             busy;
  logic             err;
  logic [1:0]       dbg_state;

  toeplitz_ctrl #(.N(N), .L(L), .WIDTH(WIDTH), .LAT_MAX(LAT_MAX), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ext_reset(ext_reset), .ext_data(ext_data),
    .ext_q(ext_q), .ext_qstrobe(ext_qstrobe), .out_q(out_q),
    .out_valid(out_valid), .out_ready(out_ready), .blk_count(blk_count),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [L-1:0] fold(input logic [N-1:0] b);
    logic [L-1:0] f;
    f = '0;
    for (int i = 0; i < N / L; i++) f ^= b[i*L +: L];
    return f;
  endfunction

  // ---------------- model state ----------------
  logic [L-1:0] exp_q[$];     // expected results, in delivery order
  logic [N-1:0] blk_q[$];     // blocks accepted from the source, not yet streamed
  logic [N-1:0] in_acc;
  int           in_nb;
  logic [N-1:0] x_acc;
  int           x_cnt;
  bit           x_active;
  bit           pend_strobe;
  logic [L-1:0] pend_q;
  bit           cur_real;
  bit           suppress;
  bit           stray_req;
  bit           rand_or;
  bit           exp_ov;
  logic [CNTW-1:0] model_cnt;
  bit           prev_ov;
  bit           prev_or;
  logic [L-1:0] prev_q;

  // ---------------- toeplitz_p emulation: drive side ----------------
  initial begin
    ext_qstrobe = 1'b0;
    ext_q       = '0;
    cur_real    = 1'b0;
    forever begin
      @(posedge clk); #1;
      ext_qstrobe = pend_strobe || stray_req;
      cur_real    = pend_strobe;
      ext_q       = pend_strobe ? pend_q : {$urandom, $urandom, $urandom, $urandom};
      pend_strobe = 1'b0;
      stray_req   = 1'b0;
    end
  end

  // Random downstream back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_or) out_ready = 1'($urandom_range(1, 0));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk(ext_reset === 1'b1, "rst_ext_reset", N'(ext_reset), N'(1));
        chk(in_ready === 1'b0, "rst_in_ready", N'(in_ready), N'(0));
        chk(ext_data === '0, "rst_ext_data", N'(ext_data), N'(0));
        exp_q.delete();
        blk_q.delete();
        in_acc = '0; in_nb = 0;
        x_active = 1'b0; x_cnt = 0;
        pend_strobe = 1'b0;
        exp_ov = 1'b0; model_cnt = '0;
        prev_ov = 1'b0;
      end else begin
        if (busy) chk(!out_valid && !in_ready, "busy_exclusive", N'({out_valid, in_ready}), N'(0));
        chk(out_valid === exp_ov, "out_valid", N'(out_valid), N'(exp_ov));
        chk(blk_count === model_cnt, "blk_count", N'(blk_count), N'(model_cnt));
        if (prev_ov && !prev_or) chk(out_q === prev_q, "out_q_hold", N'(out_q), N'(prev_q));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk(1'b0, "unexpected_result", N'(out_q), N'(0));
          else begin
            logic [L-1:0] e;
            e = exp_q.pop_front();
            chk(out_q === e, "out_q", N'(out_q), N'(e));
          end
        end
        // Source side: collect accepted beats, MSB-first, into blocks.
        if (in_valid && in_ready) begin
          in_acc = {in_acc[N-WIDTH-1:0], in_data};
          in_nb++;
          if (in_nb == NBEATS) begin
            blk_q.push_back(in_acc);
            in_nb = 0;
          end
        end
        // Extractor side: 128 beats after its reset make one block.
        if (ext_reset) begin
          chk(ext_data === '0, "arm_ext_data", N'(ext_data), N'(0));
          x_active = 1'b1; x_cnt = 0; x_acc = '0;
        end else if (x_active) begin
          x_acc = {x_acc[N-WIDTH-1:0], ext_data};
          x_cnt++;
          if (x_cnt == NBEATS) begin
            x_active = 1'b0;
            if (blk_q.size() == 0) chk(1'b0, "stream_without_block", x_acc, N'(0));
            else begin
              logic [N-1:0] eb;
              eb = blk_q.pop_front();
              chk(x_acc === eb, "stream_data", x_acc, eb);
              if (!suppress) begin
                pend_strobe = 1'b1;
                pend_q      = fold(x_acc);
                exp_q.push_back(fold(eb));
              end
            end
          end
        end else begin
          chk(ext_data === '0, "ext_data_idle", N'(ext_data), N'(0));
        end
        if (exp_ov && out_ready) exp_ov = 1'b0;
        if (ext_qstrobe && cur_real) begin
          exp_ov = 1'b1;
          model_cnt = model_cnt + CNTW'(1);
        end
      end
      prev_ov = out_valid && !reset;
      prev_or = out_ready;
      prev_q  = out_q;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_values();
    chk(in_ready === 1'b0, "rv_in_ready", N'(in_ready), N'(0));
    chk(ext_reset === 1'b1, "rv_ext_reset", N'(ext_reset), N'(1));
    chk(ext_data === '0, "rv_ext_data", N'(ext_data), N'(0));
    chk(out_q === '0, "rv_out_q", N'(out_q), N'(0));
    chk(out_valid === 1'b0, "rv_out_valid", N'(out_valid), N'(0));
    chk(blk_count === '0, "rv_blk_count", N'(blk_count), N'(0));
    chk(busy === 1'b0, "rv_busy", N'(busy), N'(0));
    chk(err === 1'b0, "rv_err", N'(err), N'(0));
  endtask

  // mode 0: 10,01 repeating; mode 1: 64x 11 then 64x 00; mode 2: random.
  task automatic send_block(input int mode, input int gap_lo, input int gap_hi);
    for (int i = 0; i < NBEATS; i++) begin
      int gap;
      bit got;
      logic [WIDTH-1:0] d;
      case (mode)
        0:       d = (i % 2 == 0) ? 2'b10 : 2'b01;
        1:       d = (i < NBEATS / 2) ? 2'b11 : 2'b00;
        default: d = WIDTH'($urandom);
      endcase
      gap = $urandom_range(gap_hi, gap_lo);
      repeat (gap) begin @(posedge clk); #1 in_valid = 1'b0; end
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = d;
      got = 1'b0;
      for (int t = 0; t < 2000 && !got; t++) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
        else begin @(posedge clk); #1; end
      end
      if (!got) begin
        chk(1'b0, "beat_accept_timeout", N'(i), N'(NBEATS));
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_ov(input int budget, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (n >= budget) begin
        chk(1'b0, "result_timeout", N'(n), N'(budget));
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n;
    logic [L-1:0] qa;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    suppress = 1'b0; stray_req = 1'b0; rand_or = 1'b0;
    pend_strobe = 1'b0; exp_ov = 1'b0; model_cnt = '0;
    in_nb = 0; in_acc = '0; x_active = 1'b0; x_cnt = 0;
    prev_ov = 1'b0; prev_or = 1'b1; prev_q = '0;

    // 1: reset hold and release
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk(in_ready === 1'b1, "post_reset_in_ready", N'(in_ready), N'(1));
    chk(dbg_state === 2'd0, "post_reset_state", N'(dbg_state), N'(0));

    // 2: continuous alternating pattern, exact ARM and latency
    send_block(0, 0, 0);
    @(negedge clk);
    chk(ext_reset === 1'b1, "arm_pulse", N'(ext_reset), N'(1));
    chk(in_ready === 1'b0, "arm_in_ready", N'(in_ready), N'(0));
    chk(busy === 1'b1, "arm_busy", N'(busy), N'(1));
    wait_ov(400, n);
    chk(n == 130, "arm_to_valid_latency", N'(n), N'(130));
    chk(out_q === '0, "alt_pattern_q", N'(out_q), N'(0));
    chk(blk_count === CNTW'(1), "blk_count_1", N'(blk_count), N'(1));
    // half-ones pattern folds to all ones
    send_block(1, 0, 0);
    wait_ov(400, n);
    chk(out_q === {L{1'b1}}, "half_ones_q", N'(out_q), N'({L{1'b1}}));

    // 3: in_valid every third cycle, same pattern
    do_reset();
    send_block(0, 2, 2);
    wait_ov(400, n);
    chk(out_q === '0, "gapped_alt_q", N'(out_q), N'(0));
    chk(blk_count === CNTW'(1), "gapped_blk_count", N'(blk_count), N'(1));

    // 4: output back-pressure holds the second block
    do_reset();
    out_ready = 1'b0;
    send_block(2, 0, 1);
    wait_ov(400, n);
    qa = out_q;
    send_block(2, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk(!in_ready && !ext_reset && !busy, "hold_no_arm", N'({in_ready, ext_reset, busy}), N'(0));
      chk(out_q === qa, "hold_out_q", N'(out_q), N'(qa));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk(ext_reset === 1'b1, "arm_after_pop", N'(ext_reset), N'(1));
    wait_ov(400, n);
    chk(blk_count === CNTW'(2), "blk_count_2", N'(blk_count), N'(2));
    @(posedge clk); #1 out_ready = 1'b1;

    // 5: suppressed strobe -> timeout; then a stray strobe in FILL
    do_reset();
    suppress = 1'b1;
    send_block(2, 0, 0);
    repeat (NBEATS + LAT_MAX + 6) @(negedge clk);
    chk(err === 1'b1, "timeout_err", N'(err), N'(1));
    chk(busy === 1'b0 && in_ready === 1'b1, "timeout_back_to_fill", N'({busy, in_ready}), N'(1));
    chk(out_valid === 1'b0, "timeout_no_valid", N'(out_valid), N'(0));
    chk(blk_count === '0, "timeout_blk_count", N'(blk_count), N'(0));
    suppress = 1'b0;
    do_reset();
    @(negedge clk);
    chk(err === 1'b0, "err_cleared_by_reset", N'(err), N'(0));
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    chk(err === 1'b1, "stray_strobe_err", N'(err), N'(1));
    chk(out_valid === 1'b0, "stray_no_valid", N'(out_valid), N'(0));

    // 6: reset in the middle of STREAM, then a clean block
    do_reset();
    send_block(2, 0, 0);
    repeat (61) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1 reset = 1'b0;
    send_block(2, 0, 1);
    wait_ov(400, n);
    chk(blk_count === CNTW'(1), "after_abort_blk_count", N'(blk_count), N'(1));

    // 7: random blocks, random gaps, random back-pressure
    rand_or = 1'b1;
    for (int b = 0; b < 4; b++) send_block(2, 0, 2);
    repeat (NBEATS * 2 + 40) @(negedge clk);
    @(posedge clk); #1 rand_or = 1'b0; out_ready = 1'b1;
    repeat (NBEATS + 40) @(negedge clk);
    chk(exp_q.size() == 0, "all_results_drained", N'(exp_q.size()), N'(0));
    chk(blk_count === CNTW'(5), "random_blk_count", N'(blk_count), N'(5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
